data_ram_bridge: RTL and testbench

//  Avalon-style slave bridge between the CPU data port and the word-wide, zero-delay data RAM.

---
 rtl/data_ram_bridge_pkg.sv | 20 ++
 rtl/data_ram_bridge_merge.sv | 20 ++
 rtl/data_ram_bridge.sv | 163 ++++++++++++++++
 tb/tb_data_ram_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_bridge_pkg.sv
// Shared types and constants for the CPU data-port to data-RAM bridge.
package data_ram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_MERGE_WR = 3'd3,
        ST_DONE     = 3'd4
    } bridge_state_t;

    localparam int BYTE_LANES = 4;
    localparam int WAIT_CNT_W = 4;

    // A partial write touches some but not all lanes and needs read-modify-write.
    function automatic logic is_partial(input logic [BYTE_LANES-1:0] be);
        return (be != '0) && (be != '1);
    endfunction

endpackage

// File: rtl/data_ram_bridge_merge.sv
// Combinational byte-lane merge: enabled lanes take the new word, the rest keep the old.
module byte_lane_merge
    import data_ram_bridge_pkg::*;
(
    input  logic [31:0]           i_old_word,
    input  logic [31:0]           i_new_word,
    input  logic [BYTE_LANES-1:0] i_byteenable,
    output logic [31:0]           o_word
);

    always_comb begin
        o_word = i_old_word;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (i_byteenable[i]) begin
                o_word[8*i +: 8] = i_new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_ram_bridge.sv
// Avalon-style slave bridge to a word-wide zero-delay RAM with programmable wait
// states and read-modify-write emulation of byte-enable writes.
module data_ram_bridge
    import data_ram_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [3:0]            byteenable,
    input  logic [31:0]           writedata,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    output logic                  protocol_error,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_read,
    output logic                  ram_write,
    output logic [31:0]           ram_writedata,
    input  logic [31:0]           ram_readdata,
    output logic [2:0]            dbg_state
);

    // Handshake: read/write are the master's valid and must stay high until
    // waitrequest is sampled low; the transaction retires on that clock edge.

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    bridge_state_t         r_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_is_write;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [31:0]           r_merged;
    logic [31:0]           r_readdata;
    logic                  r_proto_err;
    logic                  r_ram_read;
    logic                  r_ram_write;

    logic                  w_req;
    logic                  w_held;
    logic [31:0]           w_merged;
    logic                  w_unused_addr;

    assign w_req         = read | write;
    assign w_held        = r_is_write ? write : read;
    assign w_unused_addr = ^address[31:ADDR_WIDTH+2];

    byte_lane_merge u_merge (
        .i_old_word   (ram_readdata),
        .i_new_word   (r_wdata),
        .i_byteenable (r_be),
        .o_word       (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_addr      <= '0;
            r_is_write  <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_merged    <= '0;
            r_readdata  <= '0;
            r_proto_err <= 1'b0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr     <= address[ADDR_WIDTH+1:2];
                        r_is_write <= write;
                        r_be       <= byteenable;
                        r_wdata    <= writedata;
                        r_wait_cnt <= '0;
                        if ((read && write) || (address[1:0] != 2'b00)) begin
                            r_proto_err <= 1'b1;
                        end
                        if (WAIT_CYCLES > 0) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state     <= ST_ACCESS;
                            r_ram_read  <= !write || is_partial(byteenable);
                            r_ram_write <= write && (byteenable == 4'hF);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!w_held) begin
                        r_proto_err <= 1'b1;
                    end
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state     <= ST_ACCESS;
                        r_ram_read  <= !r_is_write || is_partial(r_be);
                        r_ram_write <= r_is_write && (r_be == 4'hF);
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (!w_held) begin
                        r_proto_err <= 1'b1;
                    end
                    r_ram_read <= 1'b0;
                    if (!r_is_write) begin
                        r_readdata  <= ram_readdata;
                        r_ram_write <= 1'b0;
                        r_state     <= ST_DONE;
                    end else if (is_partial(r_be)) begin
                        // Old word is on ram_readdata this cycle; capture the merge.
                        r_merged    <= w_merged;
                        r_ram_write <= 1'b1;
                        r_state     <= ST_MERGE_WR;
                    end else begin
                        r_ram_write <= 1'b0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_MERGE_WR: begin
                    if (!w_held) begin
                        r_proto_err <= 1'b1;
                    end
                    r_ram_read  <= 1'b0;
                    r_ram_write <= 1'b0;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ram_read  <= 1'b0;
                    r_ram_write <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        waitrequest = 1'b1;
        case (r_state)
            ST_IDLE: waitrequest = w_req;
            ST_DONE: waitrequest = 1'b0;
            default: waitrequest = 1'b1;
        endcase
    end

    assign readdata       = r_readdata;
    assign protocol_error = r_proto_err;
    assign ram_address    = r_addr;
    assign ram_read       = r_ram_read;
    assign ram_write      = r_ram_write;
    assign ram_writedata  = (r_state == ST_MERGE_WR) ? r_merged : r_wdata;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_data_ram_bridge.sv
// Bench for data_ram_bridge: two instances (WAIT_CYCLES=2 and 0), behavioural RAMs, scoreboard.
module tb_data_ram_bridge;

    localparam int WC0 = 2;
    localparam int WC1 = 0;

    logic        clk;
    logic        rst;
    logic        rd [2];
    logic        wr [2];
    logic [31:0] adr [2];
    logic [3:0]  be [2];
    logic [31:0] wd [2];
    logic        wreq [2];
    logic [31:0] rdat [2];
    logic        perr [2];
    logic [3:0]  ramad [2];
    logic        rram [2];
    logic        wram [2];
    logic [31:0] ramwd [2];
    logic [31:0] ramrd [2];
    logic [2:0]  dbg [2];

    logic [31:0] mem [2][16];
    int          wcnt [2] = '{0, 0};
    int          rcnt [2] = '{0, 0};
    int          last_waddr [2] = '{0, 0};
    int          last_rcyc [2] = '{0, 0};
    int          last_wcyc [2] = '{0, 0};
    int          cyc = 0;

    int          checks = 0;
    int          errors = 0;
    int          mcnt [2] = '{0, 0};
    int          done_cyc [2] = '{0, 0};
    logic [40:0] exp_q0[$];
    logic [40:0] exp_q1[$];

    data_ram_bridge #(.WAIT_CYCLES(WC0), .ADDR_WIDTH(4)) u_dut0 (
        .clk(clk), .reset(rst), .address(adr[0]), .read(rd[0]), .write(wr[0]),
        .byteenable(be[0]), .writedata(wd[0]), .waitrequest(wreq[0]), .readdata(rdat[0]),
        .protocol_error(perr[0]), .ram_address(ramad[0]), .ram_read(rram[0]),
        .ram_write(wram[0]), .ram_writedata(ramwd[0]), .ram_readdata(ramrd[0]),
        .dbg_state(dbg[0])
    );

    data_ram_bridge #(.WAIT_CYCLES(WC1), .ADDR_WIDTH(4)) u_dut1 (
        .clk(clk), .reset(rst), .address(adr[1]), .read(rd[1]), .write(wr[1]),
        .byteenable(be[1]), .writedata(wd[1]), .waitrequest(wreq[1]), .readdata(rdat[1]),
        .protocol_error(perr[1]), .ram_address(ramad[1]), .ram_read(rram[1]),
        .ram_write(wram[1]), .ram_writedata(ramwd[1]), .ram_readdata(ramrd[1]),
        .dbg_state(dbg[1])
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural zero-delay RAMs and strobe bookkeeping
    assign ramrd[0] = mem[0][ramad[0]];
    assign ramrd[1] = mem[1][ramad[1]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (wram[g]) begin
                mem[g][ramad[g]] <= ramwd[g];
                wcnt[g]          <= wcnt[g] + 1;
                last_waddr[g]    <= int'(ramad[g]);
                last_wcyc[g]     <= cyc;
            end
            if (rram[g]) begin
                rcnt[g]      <= rcnt[g] + 1;
                last_rcyc[g] <= cyc;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and pops the scoreboard at each DONE cycle
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic [40:0] ent;
            logic        have;
            if (rram[g] && wram[g]) begin
                checks++;
                errors++;
                $display("FAIL strobe_overlap inst %0d: ram_read=1 ram_write=1 required not both", g);
            end
            if (rst || !(rd[g] || wr[g])) begin
                mcnt[g] = 0;
            end else if (wreq[g]) begin
                mcnt[g] = mcnt[g] + 1;
            end else begin
                have = 1'b0;
                ent  = '0;
                if (g == 0 && exp_q0.size() > 0) begin
                    ent = exp_q0.pop_front();
                    have = 1'b1;
                end else if (g == 1 && exp_q1.size() > 0) begin
                    ent = exp_q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done inst %0d: got a DONE cycle, required none", g);
                end else begin
                    check($sformatf("latency_inst%0d", g), 32'(mcnt[g]), {24'd0, ent[40:33]});
                    if (ent[32]) begin
                        check($sformatf("readdata_inst%0d", g), rdat[g], ent[31:0]);
                    end
                end
                done_cyc[g] = cyc;
                mcnt[g] = 0;
            end
        end
    end

    // Driver: issue one transfer (called just after a rising edge), push its expectation
    task automatic xfer(input int s, input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d, input logic [31:0] exp_data,
                        input logic keep);
        int   lat;
        logic done;
        lat = ((s == 0) ? WC0 : WC1) + ((w && b != 4'h0 && b != 4'hF) ? 3 : 2);
        if (s == 0) exp_q0.push_back({8'(lat), r && !w, exp_data});
        else        exp_q1.push_back({8'(lat), r && !w, exp_data});
        rd[s] = r; wr[s] = w; adr[s] = a; be[s] = b; wd[s] = d;
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!wreq[s]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout inst %0d addr %h: waitrequest stuck high, required low", s, a);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            rd[s] = 1'b0;
            wr[s] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, r0, d_first;
        for (int g = 0; g < 2; g++) begin
            rd[g] = 1'b0; wr[g] = 1'b0; adr[g] = '0; be[g] = '0; wd[g] = '0;
        end
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst_wait_inst%0d", g), {31'd0, wreq[g]}, 32'd0);
            check($sformatf("rst_rdata_inst%0d", g), rdat[g], 32'd0);
            check($sformatf("rst_perr_inst%0d", g), {31'd0, perr[g]}, 32'd0);
            check($sformatf("rst_strobes_inst%0d", g), {30'd0, rram[g], wram[g]}, 32'd0);
            check($sformatf("rst_state_inst%0d", g), {29'd0, dbg[g]}, 32'd0);
        end
        rst = 1'b0;
        tick();

        // 1: reset in the middle of a write's wait phase
        w0 = wcnt[0];
        wr[0] = 1'b1; adr[0] = 32'h10; be[0] = 4'hF; wd[0] = 32'h1234_5678;
        tick();
        tick();
        check("t1_in_wait", {29'd0, dbg[0]}, 32'd1);
        rst = 1'b1;
        tick();
        check("t1_no_write", 32'(wcnt[0] - w0), 32'd0);
        check("t1_perr", {31'd0, perr[0]}, 32'd0);
        rst = 1'b0;
        xfer(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        check("t1_rerun_writes", 32'(wcnt[0] - w0), 32'd1);
        check("t1_mem", mem[0][4], 32'h1234_5678);

        // 2: full write then read back
        w0 = wcnt[0];
        xfer(0, 1'b0, 1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("t2_write_once", 32'(wcnt[0] - w0), 32'd1);
        check("t2_write_addr", 32'(last_waddr[0]), 32'd2);
        tick();
        xfer(0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // 3: partial write by read-modify-write
        xfer(0, 1'b0, 1'b1, 32'hC, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        w0 = wcnt[0];
        r0 = rcnt[0];
        xfer(0, 1'b0, 1'b1, 32'hC, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0);
        check("t3_reads", 32'(rcnt[0] - r0), 32'd1);
        check("t3_writes", 32'(wcnt[0] - w0), 32'd1);
        check("t3_order", 32'(last_wcyc[0] - last_rcyc[0]), 32'd1);
        check("t3_mem", mem[0][3], 32'h11BB_33DD);
        xfer(0, 1'b1, 1'b0, 32'hC, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0);
        check("t3_perr_clean", {31'd0, perr[0]}, 32'd0);

        // 4: zero wait states, back-to-back reads
        xfer(1, 1'b0, 1'b1, 32'h0, 4'hF, 32'hA5A5_0000, 32'h0, 1'b0);
        xfer(1, 1'b0, 1'b1, 32'h4, 4'hF, 32'h0000_5A5A, 32'h0, 1'b0);
        tick();
        xfer(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'hA5A5_0000, 1'b1);
        d_first = done_cyc[1];
        xfer(1, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 32'h0000_5A5A, 1'b0);
        check("t4_b2b_spacing", 32'(done_cyc[1] - d_first), 32'd3);
        check("t4_perr_clean", {31'd0, perr[1]}, 32'd0);

        // Request dropped mid-transaction
        rd[1] = 1'b1; adr[1] = 32'h0;
        tick();
        rd[1] = 1'b0;
        tick();
        tick();
        check("drop_perr", {31'd0, perr[1]}, 32'd1);
        check("drop_idle", {29'd0, dbg[1]}, 32'd0);

        // 5: misaligned read
        xfer(0, 1'b0, 1'b1, 32'h4, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        xfer(0, 1'b1, 1'b0, 32'h5, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        check("t5_perr", {31'd0, perr[0]}, 32'd1);
        xfer(0, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        check("t5_perr_sticky", {31'd0, perr[0]}, 32'd1);

        // 6: read and write together with no byte lanes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_perr_cleared", {31'd0, perr[0]}, 32'd0);
        w0 = wcnt[0];
        r0 = rcnt[0];
        xfer(0, 1'b1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
        check("t6_no_strobes", 32'((wcnt[0] - w0) + (rcnt[0] - r0)), 32'd0);
        check("t6_perr", {31'd0, perr[0]}, 32'd1);

        repeat (3) tick();
        check("q0_drained", 32'(exp_q0.size()), 32'd0);
        check("q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
